// File: rtl/plab1_imul_arb.sv
// plab1_imul_arb: two-requester round-robin front end for one shared
// multiplier. Each issued request records its requester ID in a small tag
// FIFO. The multiplier returns results in order, so the head tag tells us
// which requester the next result belongs to.
module plab1_imul_arb #(
  parameter int MSG_NBITS = 67,
  parameter int TAG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic [MSG_NBITS-1:0] in0_msg,
  input  logic                 in0_val,
  output logic                 in0_rdy,

  input  logic [MSG_NBITS-1:0] in1_msg,
  input  logic                 in1_val,
  output logic                 in1_rdy,

  output logic [MSG_NBITS-1:0] mul_req_msg,
  output logic                 mul_req_val,
  input  logic                 mul_req_rdy,

  input  logic [31:0]          mul_resp_msg,
  input  logic                 mul_resp_val,
  output logic                 mul_resp_rdy,

  output logic [31:0]          out0_msg,
  output logic                 out0_val,
  input  logic                 out0_rdy,

  output logic [31:0]          out1_msg,
  output logic                 out1_val,
  input  logic                 out1_rdy
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAG_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TAG_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // State: round-robin priority and tag FIFO (storage, pointers, occupancy)
  logic                 prio_q,   prio_d;
  logic [TAG_DEPTH-1:0] tag_q,    tag_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q,  count_d;

  logic full;
  logic empty;
  logic head;
  logic any_val;
  logic grant;
  logic issue;
  logic head_rdy;
  logic pop;

  // FIFO status and the requester ID owning the oldest outstanding result
  always_comb begin
    full  = (count_q == CNT_FULL);
    empty = (count_q == '0);
    head  = tag_q[rd_ptr_q];
  end

  // Grant selection: prio breaks ties; a lone requester always wins
  always_comb begin
    any_val = in0_val | in1_val;
    if (in0_val & in1_val) grant = prio_q;
    else                   grant = in1_val;
  end

  // Request path: forward the granted message, accept it only on a real issue.
  // Valid is independent of mul_req_rdy; reset forces the channel idle.
  always_comb begin
    mul_req_val = any_val & ~full & ~reset;
    mul_req_msg = grant ? in1_msg : in0_msg;
    issue       = mul_req_val & mul_req_rdy;
    in0_rdy     = issue & ~grant;
    in1_rdy     = issue &  grant;
  end

  // Response path: steer the result to the requester named by the head tag.
  // With no tag outstanding a stray response is neither taken nor forwarded.
  always_comb begin
    head_rdy     = head ? out1_rdy : out0_rdy;
    mul_resp_rdy = ~empty & head_rdy & ~reset;
    out0_val     = mul_resp_val & ~empty & ~head & ~reset;
    out1_val     = mul_resp_val & ~empty &  head & ~reset;
    out0_msg     = mul_resp_msg;
    out1_msg     = mul_resp_msg;
    pop          = mul_resp_val & mul_resp_rdy;
  end

  // Next state: push tag on issue, pop on response accept, rotate priority.
  // Issue already excludes the full case, so a pop never makes room the same cycle.
  always_comb begin
    prio_d   = prio_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (issue) begin
      prio_d          = ~grant;
      tag_d[wr_ptr_q] = grant;
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    end
    case ({issue, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Registers; reset drops every outstanding tag and restores priority to requester 0
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q   <= 1'b0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      prio_q   <= prio_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_plab1_imul_arb.sv
// tb_plab1_imul_arb: random sources/sinks, a behavioural in-order multiplier,
// and a per-port scoreboard of expected products checked by a separate monitor.
module tb_plab1_imul_arb;
  localparam int MSG_NBITS = 67;
  localparam int TAG_DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic [MSG_NBITS-1:0] in_msg [2];
  logic [1:0] in_val, in_rdy, out_val, out_rdy;
  logic [31:0] out_msg [2];
  logic [MSG_NBITS-1:0] mul_req_msg;
  logic mul_req_val, mul_req_rdy;
  logic [31:0] mul_resp_msg;
  logic mul_resp_val, mul_resp_rdy;

  plab1_imul_arb #(.MSG_NBITS(MSG_NBITS), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in0_msg(in_msg[0]), .in0_val(in_val[0]), .in0_rdy(in_rdy[0]),
    .in1_msg(in_msg[1]), .in1_val(in_val[1]), .in1_rdy(in_rdy[1]),
    .mul_req_msg(mul_req_msg), .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy),
    .mul_resp_msg(mul_resp_msg), .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy),
    .out0_msg(out_msg[0]), .out0_val(out_val[0]), .out0_rdy(out_rdy[0]),
    .out1_msg(out_msg[1]), .out1_val(out_val[1]), .out1_rdy(out_rdy[1])
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // knobs
  int src_max = 0;
  int sink_max = 0;
  int mul_rdy_pct = 100;
  int resp_pct = 100;
  logic force_resp = 1'b0;
  logic [1:0] sink_hold = 2'b00;

  // queues
  logic [MSG_NBITS-1:0] src_q [2][$];
  logic [31:0] exp_q [2][$];
  logic [31:0] mq [$];
  int grant_log [$];
  int grant_cyc [$];
  int rcv_cnt [2];
  int oval_cnt [2];

  function automatic logic [31:0] prod(logic [MSG_NBITS-1:0] m);
    logic [63:0] x;
    x = {32'b0, m[63:32]} * {32'b0, m[31:0]};
    return x[31:0];
  endfunction

  function automatic logic [MSG_NBITS-1:0] mk(logic [31:0] a, logic [31:0] b);
    logic [2:0] f;
    f = 3'($urandom_range(7, 0));
    return {f, a, b};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(string nm, int budget);
    int n = 0;
    while ((src_q[0].size() != 0 || src_q[1].size() != 0 ||
            exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < budget) begin
      step(1);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_timeout: got pending=%0d expected 0", nm,
               src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size());
    end
    step(2);
  endtask

  // Sources and sinks: drive on negedge, observe handshakes before the posedge
  initial begin : stim
    int sdly [2];
    int srcd [2];
    sdly[0] = 0; sdly[1] = 0; srcd[0] = 0; srcd[1] = 0;
    in_val = 2'b00; out_rdy = 2'b00;
    in_msg[0] = '0; in_msg[1] = '0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (srcd[p] > 0) begin
          srcd[p]--;
          in_val[p] = 1'b0;
        end else if (src_q[p].size() > 0) begin
          in_val[p] = 1'b1;
          in_msg[p] = src_q[p][0];
        end else begin
          in_val[p] = 1'b0;
        end
        out_rdy[p] = !sink_hold[p] && (sdly[p] == 0);
        if (sdly[p] > 0) sdly[p]--;
      end
      #2;
      for (int p = 0; p < 2; p++) begin
        if (in_val[p] && in_rdy[p]) begin
          exp_q[p].push_back(prod(in_msg[p]));
          grant_log.push_back(p);
          grant_cyc.push_back(cyc_cnt);
          void'(src_q[p].pop_front());
          srcd[p] = int'($urandom_range(src_max, 0));
        end
        if (out_val[p] && out_rdy[p]) sdly[p] = int'($urandom_range(sink_max, 0));
      end
    end
  end

  // Shared multiplier: in-order, at least one cycle of latency
  initial begin : mul_model
    logic [31:0] a, b, r;
    mul_req_rdy = 1'b0; mul_resp_val = 1'b0; mul_resp_msg = '0;
    forever begin
      @(negedge clk);
      mul_req_rdy  = ($urandom_range(99, 0) < mul_rdy_pct);
      mul_resp_val = force_resp || (mq.size() > 0 && $urandom_range(99, 0) < resp_pct);
      mul_resp_msg = (mq.size() > 0) ? mq[0] : 32'h0;
      #2;
      if (mul_resp_val && mul_resp_rdy && mq.size() > 0) void'(mq.pop_front());
      if (mul_req_val && mul_req_rdy) begin
        a = mul_req_msg[63:32];
        b = mul_req_msg[31:0];
        r = a * b;
        mq.push_back(r);
      end
    end
  end

  // Monitor: pops the expected result for whichever port completes a transfer
  initial begin : monitor
    rcv_cnt[0] = 0; rcv_cnt[1] = 0; oval_cnt[0] = 0; oval_cnt[1] = 0;
    forever begin
      @(negedge clk);
      #2;
      total++;
      if (in_rdy == 2'b11) begin
        bad++;
        $display("FAIL in_rdy_onehot: got %b expected at most one", in_rdy);
      end
      for (int p = 0; p < 2; p++) begin
        if (out_val[p]) oval_cnt[p]++;
        if (out_val[p] && out_rdy[p]) begin
          rcv_cnt[p]++;
          if (exp_q[p].size() == 0) begin
            total++; bad++;
            $display("FAIL out%0d_extra: got %0h expected none", p, out_msg[p]);
          end else begin
            chk($sformatf("out%0d_msg", p), out_msg[p], exp_q[p].pop_front());
          end
        end
      end
    end
  end

  initial begin : seq
    int base0, base1, o0;
    reset = 1'b1;
    force_resp = 1'b1;
    // reset state with requests and a stray response pending
    for (int i = 0; i < 4; i++) begin
      src_q[0].push_back(mk(32'd2, 32'd3));
      src_q[1].push_back(mk(32'd4, 32'd5));
    end
    step(3); #2;
    chk("rst_in0_rdy", 32'(in_rdy[0]), 0);
    chk("rst_in1_rdy", 32'(in_rdy[1]), 0);
    chk("rst_mul_req_val", 32'(mul_req_val), 0);
    chk("rst_mul_resp_rdy", 32'(mul_resp_rdy), 0);
    chk("rst_out0_val", 32'(out_val[0]), 0);
    chk("rst_out1_val", 32'(out_val[1]), 0);

    // first cycle out of reset: FIFO empty, stray response ignored
    step(1);
    reset = 1'b0;
    force_resp = 1'b0;
    #2;
    chk("empty_resp_rdy", 32'(mul_resp_rdy), 0);
    chk("empty_out0_val", 32'(out_val[0]), 0);
    chk("empty_out1_val", 32'(out_val[1]), 0);
    chk("issue_after_rst", 32'(mul_req_val), 1);
    wait_idle("t1", 300);
    chk("t1_ngrants", 32'(grant_log.size()), 8);
    for (int i = 0; i < grant_log.size() && i < 8; i++)
      chk($sformatf("t1_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));
    chk("t1_rcv0", 32'(rcv_cnt[0]), 4);
    chk("t1_rcv1", 32'(rcv_cnt[1]), 4);

    // only requester 1: back-to-back grants, out0 silent
    grant_log.delete(); grant_cyc.delete();
    o0 = oval_cnt[0]; base1 = rcv_cnt[1];
    for (int i = 0; i < 3; i++) src_q[1].push_back(mk($urandom, $urandom));
    wait_idle("t2", 300);
    chk("t2_ngrants", 32'(grant_log.size()), 3);
    for (int i = 0; i < grant_log.size() && i < 3; i++)
      chk($sformatf("t2_grant%0d", i), 32'(grant_log[i]), 1);
    for (int i = 0; i + 1 < grant_cyc.size() && i < 2; i++)
      chk($sformatf("t2_b2b%0d", i), 32'(grant_cyc[i+1] - grant_cyc[i]), 1);
    chk("t2_out0_quiet", 32'(oval_cnt[0] - o0), 0);
    chk("t2_rcv1", 32'(rcv_cnt[1] - base1), 3);
    grant_log.delete();
    src_q[0].push_back(mk($urandom, $urandom));
    src_q[1].push_back(mk($urandom, $urandom));
    wait_idle("t2p", 300);
    chk("t2_prio_first", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 0);

    // out0 stalled: exactly TAG_DEPTH issues, then blocked
    grant_log.delete();
    base1 = rcv_cnt[1];
    sink_hold = 2'b01;
    for (int i = 0; i < 6; i++) begin
      src_q[0].push_back(mk($urandom, $urandom));
      src_q[1].push_back(mk($urandom, $urandom));
    end
    step(15); #2;
    chk("t3_issues", 32'(grant_log.size()), TAG_DEPTH);
    chk("t3_full_req_val", 32'(mul_req_val), 0);
    chk("t3_resp_stall", 32'(mul_resp_rdy), 0);
    chk("t3_no_out1", 32'(rcv_cnt[1] - base1), 0);
    step(1);
    sink_hold = 2'b00;
    step(1); #2;
    chk("t3_pop_when_full", 32'(mul_resp_rdy), 1);
    chk("t3_full_pop_block", 32'(mul_req_val), 0);
    wait_idle("t3", 600);
    chk("t3_total_grants", 32'(grant_log.size()), 12);

    // reset with two tags outstanding and prio pointing at requester 1
    grant_log.delete();
    sink_hold = 2'b11;
    src_q[0].push_back(mk($urandom, $urandom));
    src_q[0].push_back(mk($urandom, $urandom));
    step(6); #2;
    chk("t4_outstanding", 32'(grant_log.size()), 2);
    step(1);
    reset = 1'b1;
    mq.delete(); exp_q[0].delete(); exp_q[1].delete();
    src_q[0].delete(); src_q[1].delete();
    grant_log.delete();
    sink_hold = 2'b00;
    step(2);
    reset = 1'b0;
    #2;
    chk("t4_empty_resp_rdy", 32'(mul_resp_rdy), 0);
    chk("t4_out0_val", 32'(out_val[0]), 0);
    src_q[0].push_back(mk($urandom, $urandom));
    src_q[1].push_back(mk($urandom, $urandom));
    wait_idle("t4", 300);
    chk("t4_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 0);

    // random delays, mixed signed/overflow operands
    src_max = 3; sink_max = 14; mul_rdy_pct = 70; resp_pct = 60;
    base0 = rcv_cnt[0]; base1 = rcv_cnt[1];
    for (int i = 0; i < 100; i++)
      for (int p = 0; p < 2; p++)
        if ($urandom_range(1, 0) == 0) src_q[p].push_back(mk(32'hFFFF_FFFE, 32'd3));
        else                           src_q[p].push_back(mk(32'h8000_0001, 32'h8000_0001));
    wait_idle("t5", 20000);
    chk("t5_rcv0", 32'(rcv_cnt[0] - base0), 100);
    chk("t5_rcv1", 32'(rcv_cnt[1] - base1), 100);
    chk("t5_neg_product", prod(mk(32'hFFFF_FFFE, 32'd3)), 32'hFFFF_FFFA);

    // random operands
    base0 = rcv_cnt[0]; base1 = rcv_cnt[1];
    for (int i = 0; i < 40; i++) begin
      src_q[0].push_back(mk($urandom, $urandom));
      src_q[1].push_back(mk($urandom, $urandom));
    end
    wait_idle("t6", 10000);
    chk("t6_rcv0", 32'(rcv_cnt[0] - base0), 40);
    chk("t6_rcv1", 32'(rcv_cnt[1] - base1), 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plab1_imul_arb.md
PLAB1_IMUL_ARB -- requirements
Module: plab1_imul_arb

Interface
REQ-001 Parameter: MSG_NBITS, default 67, width of the multiplier request message {func[2:0], a[31:0], b[31:0]}.
REQ-002 Parameter: TAG_DEPTH, default 4, maximum number of requests issued to the multiplier whose responses have not yet been returned.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in0_msg  input  MSG_NBITS  requester 0 request message.
REQ-006 Port: in0_val  input  1  requester 0 request valid.
REQ-007 Port: in0_rdy  output  1  requester 0 request accepted.
REQ-008 Port: in1_msg / in1_val / in1_rdy  input / input / output  MSG_NBITS / 1 / 1  requester 1 request channel, same meaning as requester 0.
REQ-009 Port: mul_req_msg  output  MSG_NBITS  request message to the shared multiplier.
REQ-010 Port: mul_req_val  output  1  request valid to the multiplier.
REQ-011 Port: mul_req_rdy  input  1  multiplier can accept a request.
REQ-012 Port: mul_resp_msg  input  32  multiplier result.
REQ-013 Port: mul_resp_val  input  1  result valid.
REQ-014 Port: mul_resp_rdy  output  1  arbiter accepts the result.
REQ-015 Port: out0_msg / out0_val / out0_rdy  output / output / input  32 / 1 / 1  response channel to requester 0.
REQ-016 Port: out1_msg / out1_val / out1_rdy  output / output / input  32 / 1 / 1  response channel to requester 1.

Function
REQ-017 Every channel SHALL use val/rdy handshaking; a transfer occurs in a cycle where val and rdy are both 1.
REQ-018 No val output SHALL depend combinationally on the rdy input of the same channel.
REQ-019 Arbitration SHALL be round-robin, driven by a 1-bit priority register prio; when both inN_val are 1, the requester named by prio is granted.
REQ-020 When exactly one inN_val is 1, that requester SHALL be granted regardless of prio.
REQ-021 mul_req_val SHALL = (in0_val | in1_val) & !full.
REQ-022 mul_req_msg SHALL equal the granted requester's msg.
REQ-023 in0_rdy and in1_rdy SHALL each be 1 only when that requester is granted, !full, and mul_req_rdy = 1; at most one SHALL be 1 in any cycle.
REQ-024 On an issue (mul_req_val & mul_req_rdy), prio SHALL be set to the requester that was not granted; prio SHALL be unchanged in all other cycles.
REQ-025 A tag FIFO of TAG_DEPTH 1-bit entries SHALL hold the requester ID of each issued request, in issue order.
  - push on issue
  - pop on mul_resp_val & mul_resp_rdy
  - full: count == TAG_DEPTH
  - empty: count == 0
REQ-026 The FIFO SHALL have no bypass: a tag pushed in cycle t is visible at the head from cycle t+1 at the earliest.
REQ-027 A push and a pop in the same cycle (FIFO neither full nor empty) SHALL leave count unchanged; read and write pointers SHALL wrap modulo TAG_DEPTH.
REQ-028 When full, issue SHALL be blocked even if a pop occurs in the same cycle.
REQ-029 out0_val SHALL = mul_resp_val & !empty & (head == 0), and out1_val SHALL = mul_resp_val & !empty & (head == 1).
REQ-030 mul_resp_rdy SHALL = !empty & out_head_rdy, where out_head_rdy is the rdy of the out channel named by head.
REQ-031 out0_msg and out1_msg SHALL both equal mul_resp_msg.
REQ-032 A response arriving while the FIFO is empty SHALL be neither accepted nor forwarded: mul_resp_rdy = 0 and both outN_val = 0.
REQ-033 Responses SHALL be routed strictly in issue order; the multiplier returns results in order.
REQ-034 A stalled out channel SHALL stall mul_resp_rdy only; request issue SHALL continue until the FIFO is full.

Reset
REQ-035 While reset = 1, the next edge SHALL set count = 0, both FIFO pointers = 0, and prio = 0.
REQ-036 While reset = 1, in0_rdy, in1_rdy, mul_req_val, mul_resp_rdy, out0_val and out1_val SHALL be 0.
REQ-037 Asserting reset mid-operation SHALL discard all outstanding tags; the bench resets the multiplier in the same cycle.

Verification
REQ-038 Both requesters continuously valid, multiplier always ready -> grants alternate 0,1,0,1 starting with 0; requester 0 receives 2*3 = 6 and requester 1 receives 4*5 = 20, each on its own out port.
REQ-039 Only requester 1 valid for 3 requests -> all 3 granted back-to-back, prio = 0 afterwards, out1 receives all results and out0_val never asserts.
REQ-040 out0_rdy held 0 with interleaved requests -> exactly 4 issues, then mul_req_val = 0 (full); releasing out0_rdy drains results in order and issue resumes.
REQ-041 mul_resp_val asserted with the FIFO empty -> mul_resp_rdy = 0 and out0_val = out1_val = 0.
REQ-042 Reset asserted with 2 tags outstanding -> after reset, count = 0 and the first new grant goes to requester 0.
REQ-043 Random src/sink delays (max 3/14) over 100 mixed -2 * 3 = -6 and 0x80000001 * 0x80000001 = 0x00000001 requests per port -> all results correct, on the correct port, in per-port order.
